core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 31 +++
 rtl/core_ctrl_acc_addr_gen.sv | 38 +++
 rtl/core_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for core_ctrl: FSM state encoding, instruction bit map,
// kernel memory base address and the idle instruction word.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LOAD, X_L0, X_EXEC, DRAIN, WAIT_OF, OF_RD, NEXT, ACC, FIN
  } state_t;

  localparam int INST_W        = 35;
  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_LSB   = 20;
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_LSB   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXEC     = 1;
  localparam int INST_LOAD     = 0;

  localparam logic [10:0] KMEM_BASE = 11'h400;

  // Memory enables are active-low, so idle holds both CEN/WEN pairs high.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C0000;

endpackage

// File: rtl/core_ctrl_acc_addr_gen.sv
// Psum address generator for the accumulation phase (built only when
// CORE_CTRL_ACC_ADDR_GEN_EN is defined); one-cycle registered latency.
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
module acc_addr_gen #(
  parameter int len_nij = 36,
  parameter int in_w    = 6,
  parameter int out_w   = 4,
  parameter int ksz     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [4:0]  o,
  input  logic [3:0]  k,
  output logic [10:0] addr
);

  localparam logic [10:0] NIJ_A  = 11'(len_nij);
  localparam logic [10:0] IN_W_A = 11'(in_w);
  localparam logic [10:0] OUT_A  = 11'(out_w);
  localparam logic [10:0] KSZ_A  = 11'(ksz);

  logic [10:0] addr_d;

  // Output pixel o maps to (row, col) in the output tile; kernel k shifts it.
  always_comb begin
    addr_d = 11'(k) * NIJ_A
           + (11'(o) / OUT_A + 11'(k) / KSZ_A) * IN_W_A
           + (11'(o) % OUT_A) + (11'(k) % KSZ_A);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr <= '0;
    else          addr <= en ? addr_d : '0;
  end

endmodule
`endif

// File: rtl/core_ctrl.sv
// Core instruction sequencer: walks weight load, activation stream, drain and
// psum write-back per kernel position. Optional ACC phase: CORE_CTRL_ACC_ADDR_GEN_EN.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int in_w     = 6,
  parameter int out_w    = 4,
  parameter int ksz      = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode_select,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  localparam logic [6:0]  COL_C    = 7'(col);
  localparam logic [6:0]  NIJ_C    = 7'(len_nij);
  localparam logic [6:0]  DRAIN_C  = 7'(row + col);
  localparam logic [10:0] COL_A    = 11'(col);
  localparam logic [10:0] NIJ_A    = 11'(len_nij);
  localparam logic [3:0]  KIJ_LAST = 4'(len_kij - 1);

  localparam int W_MAX = 32'(KMEM_BASE) + len_kij * col - 1;
  localparam int P_MAX = len_kij * len_nij - 1;
  localparam int A_MAX = (len_kij - 1) * len_nij
                       + ((len_onij - 1) / out_w + (ksz - 1)) * in_w
                       + (out_w - 1) + (ksz - 1);

  // Every address lives in 11 bits and every phase length in the 7-bit counter.
  if (W_MAX > 2047 || P_MAX > 2047 || A_MAX > 2047 || len_nij > 126 ||
      row + col > 126 || len_kij > 15 || len_onij > 32) begin : g_param_err
    $error("core_ctrl: parameters overflow address or counter width");
  end

  state_t            state, state_next;
  logic [6:0]        cnt, cnt_next;
  logic [3:0]        kij_next;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              done_d;

`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
  localparam logic [6:0] KIJ_C     = 7'(len_kij);
  localparam logic [4:0] ONIJ_LAST = 5'(len_onij - 1);

  logic [4:0]  o_cnt, o_next;
  logic        gen_en;
  logic [10:0] gen_addr;

  acc_addr_gen #(
    .len_nij (len_nij),
    .in_w    (in_w),
    .out_w   (out_w),
    .ksz     (ksz)
  ) u_acc_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (gen_en),
    .o       (o_cnt),
    .k       (cnt[3:0]),
    .addr    (gen_addr)
  );

  // The generator register lines up with inst_q, so its address is merged in.
  assign inst = inst_q | ({{(INST_W-11){1'b0}}, gen_addr} << INST_AP_LSB);
`else
  assign inst = inst_q;
`endif

  assign busy = (state != IDLE);

  // Each counted phase spends one extra cycle at cnt == length as its idle gap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 7'd1;
    kij_next   = kij_idx;
    done_d     = 1'b0;
    inst_d     = INST_IDLE;
    inst_d[INST_MODE] = mode_select;
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
    o_next = o_cnt;
    gen_en = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          state_next = W_L0;
          kij_next   = '0;
        end
      end
      W_L0: begin
        if (cnt < COL_C) begin
          inst_d[INST_CEN_X] = 1'b0;
          inst_d[INST_L0_WR] = 1'b1;
          inst_d[INST_AX_LSB +: 11] = KMEM_BASE + 11'(kij_idx) * COL_A + 11'(cnt);
        end else begin
          state_next = W_LOAD;
          cnt_next   = '0;
        end
      end
      W_LOAD: begin
        if (cnt < COL_C) begin
          inst_d[INST_L0_RD] = 1'b1;
          inst_d[INST_LOAD]  = 1'b1;
        end else begin
          state_next = X_L0;
          cnt_next   = '0;
        end
      end
      X_L0: begin
        if (cnt < NIJ_C) begin
          inst_d[INST_CEN_X] = 1'b0;
          inst_d[INST_L0_WR] = 1'b1;
          inst_d[INST_AX_LSB +: 11] = 11'(cnt);
        end else begin
          state_next = X_EXEC;
          cnt_next   = '0;
        end
      end
      X_EXEC: begin
        if (cnt < NIJ_C) begin
          inst_d[INST_L0_RD] = 1'b1;
          inst_d[INST_EXEC]  = 1'b1;
        end else begin
          state_next = DRAIN;
          cnt_next   = '0;
        end
      end
      DRAIN: begin
        if (cnt < DRAIN_C) begin
          inst_d[INST_L0_RD] = 1'b1;
          inst_d[INST_EXEC]  = 1'b1;
        end else begin
          state_next = WAIT_OF;
          cnt_next   = '0;
        end
      end
      WAIT_OF: begin
        cnt_next = '0;
        if (ofifo_valid) state_next = OF_RD;
      end
      OF_RD: begin
        // Reads lead writes by one cycle: the word popped at i lands at i+1.
        if (cnt < NIJ_C) inst_d[INST_OFIFO_RD] = 1'b1;
        if (cnt != '0) begin
          inst_d[INST_CEN_P] = 1'b0;
          inst_d[INST_WEN_P] = 1'b0;
          inst_d[INST_AP_LSB +: 11] = 11'(kij_idx) * NIJ_A + 11'(cnt) - 11'd1;
        end
        if (cnt == NIJ_C) begin
          state_next = NEXT;
          cnt_next   = '0;
        end
      end
      NEXT: begin
        cnt_next = '0;
        kij_next = kij_idx + 4'd1;
        if (kij_idx == KIJ_LAST) begin
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
          state_next = ACC;
          o_next     = '0;
`else
          state_next = FIN;
`endif
        end else begin
          state_next = W_L0;
        end
      end
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
      ACC: begin
        if (cnt < KIJ_C) begin
          inst_d[INST_CEN_P] = 1'b0;
          gen_en = 1'b1;
        end
        if (cnt != '0 && cnt <= KIJ_C) inst_d[INST_ACC] = 1'b1;
        if (cnt == KIJ_C + 7'd1) begin
          cnt_next = '0;
          if (o_cnt == ONIJ_LAST) state_next = FIN;
          else                    o_next     = o_cnt + 5'd1;
        end
      end
`endif
      FIN: begin
        done_d     = 1'b1;
        cnt_next   = '0;
        kij_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      kij_idx <= '0;
      inst_q  <= INST_IDLE;
      done    <= 1'b0;
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
      o_cnt   <= '0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      kij_idx <= kij_next;
      inst_q  <= inst_d;
      done    <= done_d;
`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
      o_cnt   <= o_next;
`endif
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed self-checking bench for core_ctrl: reset/idle word, kij-0 phase
// walk, WAIT_OF hold, async reset mid-run, restart and run completion.
module tb_core_ctrl;

  localparam logic [34:0] IDLE_W = 35'h1_800C0000;
  localparam logic [34:0] LOAD_W = 35'h1_800C0009;
  localparam logic [34:0] EXEC_W = 35'h1_800C000A;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode_select;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int   n_checks = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  logic acc_seen = 1'b0;

`ifdef CORE_CTRL_ACC_ADDR_GEN_EN
  int acc_exp [9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
`endif

  core_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mode_select (mode_select),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (inst[33] === 1'b1) acc_seen = 1'b1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] xmem_word(input logic [10:0] a);
    logic [34:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[2]  = 1'b1;
    w[17:7] = a;
    return w;
  endfunction

  function automatic logic [34:0] ofrd_word(input int c, input int kij);
    logic [34:0] w;
    w = IDLE_W;
    if (c < 36) w[6] = 1'b1;
    if (c >= 1) begin
      w[32] = 1'b0;
      w[31] = 1'b0;
      w[30:20] = 11'(kij * 36 + c - 1);
    end
    return w;
  endfunction

  function automatic logic [34:0] acc_word(input int k, input int a);
    logic [34:0] w;
    w = IDLE_W;
    w[32] = 1'b0;
    w[30:20] = 11'(a);
    if (k != 0) w[33] = 1'b1;
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; mode_select = 1'b0; ofifo_valid = 1'b1;
    repeat (3) step();
    check("rst_inst", inst, IDLE_W);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kij", kij_idx, 0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_inst", inst, IDLE_W);
    check("idle_busy", busy, 0);
    mode_select = 1'b1;
    step();
    check("mode_bit", inst, IDLE_W | (35'd1 << 34));
    mode_select = 1'b0;
    step();
    check("mode_clear", inst, IDLE_W);

    // First run, kij 0, ofifo_valid held high.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_idle", inst, IDLE_W);
    for (int i = 0; i < 8; i++) begin step(); check("w_l0", inst, xmem_word(11'h400 + 11'(i))); end
    step(); check("gap_w_l0", inst, IDLE_W);
    for (int i = 0; i < 8; i++) begin step(); check("w_load", inst, LOAD_W); end
    step(); check("gap_w_load", inst, IDLE_W);
    for (int i = 0; i < 36; i++) begin step(); check("x_l0", inst, xmem_word(11'(i))); end
    step(); check("gap_x_l0", inst, IDLE_W);
    for (int i = 0; i < 36; i++) begin step(); check("x_exec", inst, EXEC_W); end
    step(); check("gap_x_exec", inst, IDLE_W);
    for (int i = 0; i < 16; i++) begin step(); check("drain", inst, EXEC_W); end
    step(); check("gap_drain", inst, IDLE_W);
    step(); check("wait_of_pass", inst, IDLE_W);
    for (int c = 0; c < 37; c++) begin step(); check("of_rd_k0", inst, ofrd_word(c, 0)); end
    ofifo_valid = 1'b0;
    step();
    check("gap_of_rd", inst, IDLE_W);
    check("kij_1", kij_idx, 1);

    // kij 1: hold ofifo_valid low through WAIT_OF.
    step(); check("w_l0_kij1", inst, xmem_word(11'h408));
    repeat (108) step();
    for (int i = 0; i < 20; i++) begin step(); check("wait_of_hold", inst, IDLE_W); end
    check("wait_of_busy", busy, 1);
    ofifo_valid = 1'b1;
    step(); check("of_rise_gap", inst, IDLE_W);
    for (int c = 0; c < 37; c++) begin step(); check("of_rd_k1", inst, ofrd_word(c, 1)); end

    // Reset during X_EXEC of kij 4.
    for (int n = 0; n < 1000 && kij_idx !== 4'd4; n++) step();
    check("reach_kij4", kij_idx, 4);
    for (int n = 0; n < 300 && inst[1] !== 1'b1; n++) step();
    check("reach_exec", inst, EXEC_W);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("async_inst", inst, IDLE_W);
    check("async_busy", busy, 0);
    check("async_kij", kij_idx, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (4) step();
    check("no_resume_busy", busy, 0);
    check("no_resume_inst", inst, IDLE_W);

    // Second run to completion.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    step();
    check("restart_w_l0", inst, xmem_word(11'h400));
    check("restart_kij", kij_idx, 0);
    for (int n = 0; n < 1500 && kij_idx !== 4'd8; n++) step();
    check("reach_kij8", kij_idx, 8);
    for (int n = 0; n < 300 && inst[6] !== 1'b1; n++) step();
    check("of_rd8_first", inst, ofrd_word(0, 8));
    repeat (36) step();
    check("of_rd8_last", inst, ofrd_word(36, 8));
    step();
    check("of_rd8_gap", inst, IDLE_W);
    check("of_rd8_gap_done", done, 0);
`ifndef CORE_CTRL_ACC_ADDR_GEN_EN
    step();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    step();
    check("done_drop", done, 0);
`else
    repeat (56) step();
    for (int k = 0; k < 9; k++) begin
      check("acc_addr_o5", inst[30:20], acc_exp[k]);
      check("acc_word_o5", inst, acc_word(k, acc_exp[k]));
      step();
    end
    check("acc_trail", inst, IDLE_W | (35'd1 << 33));
    step();
    check("acc_gap", inst, IDLE_W);
    for (int n = 0; n < 300 && done !== 1'b1; n++) step();
    check("done_pulse", done, 1);
    step();
    check("done_drop", done, 0);
`endif
    repeat (5) step();
    check("done_once", done_cnt, 1);
    check("end_busy", busy, 0);
`ifndef CORE_CTRL_ACC_ADDR_GEN_EN
    check("acc_never", acc_seen, 0);
`else
    check("acc_seen", acc_seen, 1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
